mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM pipeline stage and a word-wide data memory.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned H/HU/W accesses instead of aligning them.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  misalign,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE} state_t;

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic [1:0]            r_off;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rsp_valid;
    logic                  r_misalign;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_misal;
    logic                  w_reject;
    logic                  w_go;
    logic                  w_is_sw;
    logic [1:0]            w_off;
    logic [4:0]            w_shift;
    logic [DATA_WIDTH-1:0] w_lane;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_unused;

    // Address bits above the memory window are dropped, so accesses wrap.
    assign w_unused = ^req_addr[31:AW+2];

    assign w_accept  = req_valid && req_ready;
    assign w_illegal = (req_we && req_funct3[2]) || (req_funct3[1:0] == 2'b11)
                    || (req_funct3[2:1] == 2'b11);
    assign w_is_sw   = req_we && (req_funct3[1:0] == 2'b10);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_off   = req_addr[1:0];
`else
    assign w_misal = 1'b0;
    assign w_off   = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} :
                     (req_funct3[1:0] == 2'b10) ? 2'b00 : req_addr[1:0];
`endif

    assign w_reject = w_illegal || w_misal;
    assign w_go     = w_accept && !w_reject;

    assign req_ready = (r_state == IDLE) && !RESET;
    assign mem_read  = w_go && !w_is_sw;
    assign mem_write = (w_go && w_is_sw) || ((r_state == RMW_MERGE) && !RESET);
    assign mem_addr  = (r_state == IDLE) ? req_addr[AW+1:2] : r_addr;

    // Byte/halfword lane of the fetched word, and the merge for partial stores.
    assign w_shift  = {r_off, 3'b000};
    assign w_lane   = mem_dout >> w_shift;
    assign w_mask   = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
    assign w_merged = (mem_dout & ~w_mask) | ((r_wdata << w_shift) & w_mask);

    assign mem_write_data = (r_state == RMW_MERGE) ? w_merged : req_wdata;

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {24'h000000, w_lane[7:0]};
            3'b101:  w_load = {16'h0000, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            // NOTE: only control state is reset; the request latches are always written before use.
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_misalign  <= w_accept && w_reject;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr[AW+1:2];
                        r_off    <= w_off;
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata;
                        if (!w_reject) begin
                            if (!req_we)
                                r_state <= LOAD_WAIT;
                            else if (!w_is_sw)
                                r_state <= RMW_MERGE;
                        end
                    end
                end
                LOAD_WAIT: begin
                    r_rdata     <= w_load;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                RMW_MERGE: r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random traffic
// checked against a byte-level reference model of the data memory.
module tb_mem_access_unit;

    localparam int MEM_DEPTH = 1024;
    localparam int AW        = $clog2(MEM_DEPTH);
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          RESET;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          misalign;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic          mem_write;
    logic          mem_read;
    logic [31:0]   mem_dout;

    logic [31:0] dmem    [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk            (clk),
        .RESET          (RESET),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .misalign       (misalign),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_dout       (mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous data memory: read data appears the cycle after mem_read and holds.
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr] <= mem_write_data;
        if (mem_read)  mem_dout <= dmem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int offset_of(input logic [31:0] addr, input logic [2:0] f3);
        int off;
        off = addr % 4;
        if (!CHK) off = off - (off % size_of(f3));
        return off;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int sz, off;
        logic [31:0] val;
        sz  = size_of(f3);
        off = offset_of(addr, f3);
        val = '0;
        for (int i = 0; i < sz; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
        if (!f3[2])
            for (int i = 8*sz; i < 32; i++) val[i] = val[8*sz-1];
        return val;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] f3, input logic [31:0] wdata);
        int sz, off;
        logic [31:0] val;
        sz  = size_of(f3);
        off = offset_of(addr, f3);
        val = word;
        for (int i = 0; i < sz; i++) val[8*(off+i) +: 8] = wdata[8*i +: 8];
        return val;
    endfunction

    task automatic transact(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata, input string tag);
        int          widx;
        bit          illegal, misal, reject, sw, rmw;
        logic [31:0] new_word;
        widx     = (addr >> 2) % MEM_DEPTH;
        illegal  = (we && f3 >= 4) || (f3 == 3) || (f3 >= 6);
        misal    = CHK && ((addr % size_of(f3)) != 0);
        reject   = illegal || misal;
        sw       = we && (f3 == 3'b010);
        rmw      = we && !sw;
        new_word = ref_store(ref_mem[widx], addr, f3, wdata);

        @(negedge clk);
        check({tag, " idle rsp_valid"}, rsp_valid, 0);
        check({tag, " idle misalign"}, misalign, 0);
        check({tag, " held rsp_rdata"}, rsp_rdata, last_rdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        check({tag, " T req_ready"}, req_ready, 1);
        check({tag, " T mem_read"}, mem_read, !reject && !sw);
        check({tag, " T mem_write"}, mem_write, !reject && sw);
        check({tag, " T mem_addr"}, mem_addr, widx);
        if (!reject && sw) check({tag, " T mem_write_data"}, mem_write_data, wdata);

        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check({tag, " T+1 misalign"}, misalign, reject);
        check({tag, " T+1 rsp_valid"}, rsp_valid, 0);
        check({tag, " T+1 req_ready"}, req_ready, reject || sw);
        check({tag, " T+1 mem_read"}, mem_read, 0);
        check({tag, " T+1 mem_write"}, mem_write, !reject && rmw);
        if (!reject && rmw) begin
            check({tag, " T+1 merge data"}, mem_write_data, new_word);
            check({tag, " T+1 mem_addr"}, mem_addr, widx);
        end
        if (!reject && we) ref_mem[widx] = new_word;

        if (!reject) begin
            @(negedge clk);
            #1;
            check({tag, " T+2 req_ready"}, req_ready, 1);
            check({tag, " T+2 rsp_valid"}, rsp_valid, !we);
            if (!we) begin
                check({tag, " T+2 rsp_rdata"}, rsp_rdata, exp_rdata);
                last_rdata = exp_rdata;
            end else begin
                check({tag, " memory word"}, dmem[widx], ref_mem[widx]);
            end
        end
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_dout   = '0;
        last_rdata = '0;
        RESET      = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = '0;

        // Reset with a request pending: no memory traffic, registered outputs cleared.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset req_ready", req_ready, 0);
        check("reset mem_read", mem_read, 0);
        check("reset mem_write", mem_write, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset misalign", misalign, 0);
        req_valid = 1'b0;
        RESET     = 1'b0;

        dmem[4]    = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;

        transact(0, 3'b010, 32'h10, 0, 32'h8899AABB, "LW 0x10");
        transact(0, 3'b000, 32'h13, 0, 32'hFFFFFF88, "LB 0x13");
        transact(0, 3'b100, 32'h13, 0, 32'h00000088, "LBU 0x13");
        transact(0, 3'b001, 32'h12, 0, 32'hFFFF8899, "LH 0x12");
        transact(0, 3'b101, 32'h10, 0, 32'h0000AABB, "LHU 0x10");
        transact(0, 3'b010, 32'h12, 0, 32'h8899AABB, "LW 0x12");
        transact(1, 3'b000, 32'h11, 32'h123456CC, 0, "SB 0x11");
        check("SB 0x11 word4", dmem[4], 32'h8899CCBB);
        transact(1, 3'b001, 32'h12, 32'h00001234, 0, "SH 0x12");
        check("SH 0x12 word4", dmem[4], 32'h1234CCBB);
        transact(1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, "illegal SBU");
        transact(0, 3'b011, 32'h10, 0, 0, "illegal f3 011");

        // Back-to-back word stores.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
        #1;
        check("b2b SW0 req_ready", req_ready, 1);
        check("b2b SW0 mem_write", mem_write, 1);
        check("b2b SW0 mem_addr", mem_addr, 0);
        @(negedge clk);
        req_addr = 32'h4; req_wdata = 32'h01020304;
        #1;
        check("b2b SW1 req_ready", req_ready, 1);
        check("b2b SW1 mem_write", mem_write, 1);
        check("b2b SW1 mem_addr", mem_addr, 1);
        check("b2b SW1 data", mem_write_data, 32'h01020304);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("b2b req_ready after", req_ready, 1);
        check("b2b word0", dmem[0], 32'hDEADBEEF);
        check("b2b word1", dmem[1], 32'h01020304);
        ref_mem[0] = 32'hDEADBEEF;
        ref_mem[1] = 32'h01020304;

        // Reset during RMW_MERGE aborts the write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h000000A5;
        #1;
        check("rmw abort T mem_read", mem_read, 1);
        @(negedge clk);
        req_valid = 1'b0;
        RESET     = 1'b1;
        #1;
        check("rmw abort mem_write", mem_write, 0);
        check("rmw abort req_ready", req_ready, 0);
        @(negedge clk);
        RESET = 1'b0;
        #1;
        check("rmw abort ready after", req_ready, 1);
        check("rmw abort word4", dmem[4], 32'h1234CCBB);
        last_rdata = '0;

        // Reset during LOAD_WAIT discards the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        RESET     = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        #1;
        check("load abort rsp_valid", rsp_valid, 0);
        check("load abort rsp_rdata", rsp_rdata, 0);
        check("load abort req_ready", req_ready, 1);

        // Random traffic over 16 words, upper address bits exercise wrap-around.
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        for (int n = 0; n < 80; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_addr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            r_wdata = $urandom;
            transact(r_we, r_f3, r_addr, r_wdata,
                     ref_load(ref_mem[(r_addr >> 2) % MEM_DEPTH], r_addr, r_f3), "random");
        end
        for (int i = 0; i < 16; i++) check("final word", dmem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
